// File: rtl/code_link_pkg.sv
// Frame-format constants and types shared by both ends of the 8-bit serial
// keypad-code link. The transmitter uses the same package.
//   CODE_W     : bits per frame, sent MSB first
//   VALID_BIT  : bit that is 1 in every valid code (first bit on the line)
//   rx_state_e : receiver frame FSM states
//   maj3       : 2-of-3 majority used by the bit voter
package code_link_pkg;

  localparam int CODE_W    = 8;
  localparam int VALID_BIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    DONE
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/code_receiver_if.sv
// Signal bundle between the line front end / code consumer and the receiver.
//   serial_in  : raw serial line, idle low
//   code       : last good code received (bit7 = first bit on the line)
//   code_valid : one-cycle pulse when code updates
//   frame_err  : one-cycle pulse when a start edge fails its mid-bit check
//   busy       : receiver is inside a frame
// master = line driver / code consumer side, slave = receiver.
interface code_receiver_if;
  import code_link_pkg::*;

  logic              serial_in;
  logic [CODE_W-1:0] code;
  logic              code_valid;
  logic              frame_err;
  logic              busy;

  modport master (
    output serial_in,
    input  code, code_valid, frame_err, busy
  );

  modport slave (
    input  serial_in,
    output code, code_valid, frame_err, busy
  );

endinterface

// File: rtl/rx_bit_sampler.sv
// Front end of the code receiver: brings the asynchronous serial line into the
// clk domain and produces the per-cycle signals the frame FSM decides on.
//   clk, reset : system clock, synchronous active-high reset
//   serial_in  : asynchronous serial line
//   s_in       : synchronized line
//   rise       : s_in is 1 now and was 0 one cycle ago
//   vote       : majority of s_in over the current and two previous cycles;
//                sampled by the FSM when its bit counter sits at HALF+1, which
//                makes the window counts HALF-1, HALF, HALF+1
module rx_bit_sampler
  import code_link_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  output logic s_in,
  output logic rise,
  output logic vote
);

  // sync_q[1] is the synchronized line; sync_q[0] is the metastability stage.
  logic [1:0] sync_q, sync_d;
  // hist_q[0] = s_in one cycle old, hist_q[1] = s_in two cycles old.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[0], serial_in};
    hist_d = {hist_q[0], sync_q[1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign s_in = sync_q[1];
  assign rise = sync_q[1] & ~hist_q[0];
  assign vote = maj3(sync_q[1], hist_q[0], hist_q[1]);

endmodule

// File: rtl/code_receiver.sv
// Receive end of the 8-bit serial keypad-code link. Waits for the line to be
// low for IDLE_BITS bit periods, locks to the next rising edge, checks the
// start bit at mid-bit, then majority-votes the remaining seven bits and
// presents the code with a one-cycle valid strobe.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : code_receiver_if slave (serial_in in; code, code_valid,
//                frame_err, busy out)
// Parameters:
//   CLKS_PER_BIT : clk cycles per bit period (even, >= 8)
//   IDLE_BITS    : low bit periods required before a start edge is accepted
module code_receiver
  import code_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int IDLE_BITS    = 2
) (
  input  logic             clk,
  input  logic             reset,
  code_receiver_if.slave   bus
);

  localparam int HALF     = CLKS_PER_BIT / 2;
  localparam int IDLE_LEN = IDLE_BITS * CLKS_PER_BIT;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int GAP_W    = $clog2(IDLE_LEN + 1);
  localparam int IDX_W    = $clog2(CODE_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(HALF + 1);
  localparam logic [GAP_W-1:0] GAP_ARM  = GAP_W'(IDLE_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(IDLE_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_W - 1);

  logic s_in, rise, vote;

  rx_bit_sampler u_sampler (
    .clk       (clk),
    .reset     (reset),
    .serial_in (bus.serial_in),
    .s_in      (s_in),
    .rise      (rise),
    .vote      (vote)
  );

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic              vote_pt;

  // Bit-period counter runs freely from the start edge; it never resyncs.
  assign cnt_inc = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  assign vote_pt = (cnt_q == CNT_VOTE);

  // NOTE: every signal gets its hold value before the case statement, so no
  // path through the decode leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    code_d      = code_q;
    busy_d      = busy_q;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Arm only after IDLE_LEN consecutive low samples; a high sample
        // on the arming cycle restarts the count instead of arming.
        if (s_in) begin
          gap_d = '0;
        end else if (gap_q == GAP_ARM) begin
          gap_d   = GAP_SAT;
          state_d = ARMED;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ARMED: begin
        if (rise) begin
          // The edge cycle is count 0, so the first START cycle is count 1.
          state_d   = START;
          cnt_d     = CNT_W'(1);
          bit_idx_d = '0;
          busy_d    = 1'b1;
        end
      end

      START: begin
        cnt_d = cnt_inc;
        if (vote_pt) begin
          if (vote) begin
            shift_d   = CODE_W'(1);
            bit_idx_d = IDX_W'(1);
            state_d   = DATA;
          end else begin
            frame_err_d = 1'b1;
            busy_d      = 1'b0;
            gap_d       = '0;
            state_d     = IDLE;
          end
        end
      end

      DATA: begin
        cnt_d = cnt_inc;
        if (vote_pt) begin
          shift_d = {shift_q[CODE_W-2:0], vote};
          if (bit_idx_q == IDX_LAST) begin
            // Load the output as DONE is entered so code and code_valid
            // change together.
            code_d  = {shift_q[CODE_W-2:0], vote};
            state_d = DONE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        gap_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      code_q      <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      code_q      <= code_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.code       = code_q;
  assign bus.code_valid = (state_q == DONE);
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule
